trace_capture_writer: RTL and testbench
=======================================

TRACE_CAPTURE_WRITER -- requirements
Module: trace_capture_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, trace memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, trace word width.
REQ-003 SHALL have parameter DEPTH, default 16384, trace memory words (2**ADDR_W).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port st_data  in  DATA_W  incoming trace word.
REQ-007 SHALL have port st_valid  in  1  st_data valid.
REQ-008 SHALL have port st_ready  out  1  block accepts a word; transfer = st_valid & st_ready.
REQ-009 SHALL have port arm  in  1  single-cycle start-capture pulse.
REQ-010 SHALL have port abort  in  1  single-cycle return-to-idle pulse.
REQ-011 SHALL have port trigger  in  1  trigger event, sampled each cycle.
REQ-012 SHALL have port post_count  in  ADDR_W  words to store after the trigger word; sampled on trigger.
REQ-013 SHALL have port mem_address  out  ADDR_W  trace memory write address.
REQ-014 SHALL have port mem_byteenable  out  4  constant 4'hF.
REQ-015 SHALL have port mem_chipselect  out  1  memory select, equal to mem_write.
REQ-016 SHALL have port mem_write  out  1  memory write strobe.
REQ-017 SHALL have port mem_writedata  out  DATA_W  trace word to memory.
REQ-018 SHALL have port state  out  2  0 IDLE, 1 PRE, 2 POST, 3 DONE.
REQ-019 SHALL have port done  out  1  high while in DONE.
REQ-020 SHALL have port wrapped  out  1  write pointer has wrapped since arm.
REQ-021 SHALL have port trig_addr  out  ADDR_W  address of trigger word.
REQ-022 SHALL have port wr_ptr  out  ADDR_W  next write address.

Function
REQ-023 IDLE: st_ready=0; arm -> PRE; wr_ptr, wrapped, trig_addr cleared to 0 on that edge.
REQ-024 PRE and POST: st_ready=1; each transfer writes st_data at wr_ptr, then wr_ptr increments modulo DEPTH.
REQ-025 Write timing: a transfer in cycle N drives mem_write=mem_chipselect=1, mem_address=old wr_ptr, mem_writedata=st_data in cycle N+1, for exactly one cycle; mem_* outputs are registered.
REQ-026 wrapped sets when wr_ptr increments from DEPTH-1 to 0 and stays set until next arm or reset.
REQ-027 PRE, trigger=1 with transfer: that word is the trigger word; trig_addr=its address; remaining=post_count; next state POST, or DONE if post_count=0.
REQ-028 PRE, trigger=1 without transfer: trig_addr=wr_ptr; remaining=post_count; next state POST, or DONE if post_count=0; the next word written is at trig_addr and counts toward remaining.
REQ-029 POST: trigger ignored; each transfer decrements remaining; transfer with remaining=1 -> DONE on that edge.
REQ-030 DONE: st_ready=0, done=1; arm -> PRE with REQ-023 clears.
REQ-031 arm in PRE or POST SHALL be ignored.
REQ-032 abort in any state -> IDLE next edge; a write already registered for cycle N+1 still completes; abort wins over simultaneous arm or trigger.
REQ-033 Word count post trigger never exceeds DEPTH-1, so the trigger word is never overwritten.

Reset
REQ-034 reset_n low SHALL immediately force state=IDLE, st_ready=0, mem_write=0, mem_chipselect=0, mem_address=0, mem_writedata=0, wr_ptr=0, trig_addr=0, wrapped=0, done=0, remaining=0.
REQ-035 Reset mid-capture SHALL discard the capture with no further memory writes; reset release is synchronized to clk.

Structure
REQ-036 Package trace_capture_pkg SHALL hold ADDR_W, DATA_W, DEPTH defaults and the 2-bit state encoding.
REQ-037 Block SHALL be a single module with no sub-modules; mem_* ports connect directly to the trace memory write slave.

Verification
REQ-038 Arm; 10 words 0xA0..0xA9, trigger with word 4, post_count=3 -> addr 0..7 written, trig_addr=4, DONE after word 7, words 8-9 not accepted.
REQ-039 Arm; 16390 words, trigger on word 16388, post_count=1 -> wrapped=1, trig_addr=4, final wr_ptr=6, DONE.
REQ-040 Arm; trigger with no valid, post_count=0 -> DONE next edge, trig_addr=0, zero memory writes.
REQ-041 Arm; trigger and abort in same cycle -> IDLE, st_ready=0 next cycle, trig_addr unchanged.
REQ-042 Arm; 5 words; assert reset_n low mid-stream -> all outputs at reset values immediately, no mem_write afterwards.
REQ-043 Throttled st_valid (1 of 3 cycles), post_count=2 -> mem_write pulses exactly one cycle after each transfer, address sequential.

Source files
------------

// File: rtl/trace_capture_writer_pkg.sv
// Shared defaults and state encoding for the trace capture writer.
package trace_capture_pkg;

  localparam int TRACE_ADDR_W = 14;
  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_DEPTH  = 1 << TRACE_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/trace_capture_writer_if.sv
// Trace word stream (valid/ready) and trace memory write port bundles.
interface trace_stream_if #(
  parameter int DATA_W = trace_capture_pkg::TRACE_DATA_W
) ();
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;

  modport master (output st_data, output st_valid, input  st_ready);
  modport slave  (input  st_data, input  st_valid, output st_ready);
endinterface

interface trace_mem_if #(
  parameter int ADDR_W = trace_capture_pkg::TRACE_ADDR_W,
  parameter int DATA_W = trace_capture_pkg::TRACE_DATA_W
) ();
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;

  modport master (
    output mem_address, output mem_byteenable, output mem_chipselect,
    output mem_write, output mem_writedata
  );
  modport slave (
    input mem_address, input mem_byteenable, input mem_chipselect,
    input mem_write, input mem_writedata
  );
endinterface

// File: rtl/trace_capture_writer.sv
// Circular pre/post-trigger trace capture into a write-only trace memory.
// Memory write lands one cycle after each accepted word; st_ready is high only in PRE/POST.
module trace_capture_writer
  import trace_capture_pkg::*;
#(
  parameter int ADDR_W = TRACE_ADDR_W,
  parameter int DATA_W = TRACE_DATA_W,
  parameter int DEPTH  = TRACE_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  trace_stream_if.slave     st,
  trace_mem_if.master       mem,
  input  logic              arm,
  input  logic              abort,
  input  logic              trigger,
  input  logic [ADDR_W-1:0] post_count,
  output logic [1:0]        state,
  output logic              done,
  output logic              wrapped,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] wr_ptr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] trig_q, trig_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wrap_q, wrap_d;
  logic              ready;
  logic              xfer;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  assign ready = (state_q == ST_PRE) || (state_q == ST_POST);
  assign xfer  = st.st_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      trig_q  <= '0;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      trig_q  <= trig_d;
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    trig_d  = trig_q;
    ptr_d   = ptr_q;
    wrap_d  = wrap_q;

    // A word already handshaken is always stored, even in an abort cycle.
    if (xfer) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST_ADDR) wrap_d = 1'b1;
    end

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d = ST_PRE;
            ptr_d   = '0;
            wrap_d  = 1'b0;
            trig_d  = '0;
          end
        end
        ST_PRE: begin
          // Without a word this cycle, the next word lands at trig_addr and counts as post.
          if (trigger) begin
            trig_d  = ptr_q;
            rem_d   = post_count;
            state_d = (post_count == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (xfer) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == ADDR_W'(1)) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_q <= xfer;
      if (xfer) begin
        addr_q <= ptr_q;
        data_q <= st.st_data;
      end
    end
  end

  assign st.st_ready        = ready;
  assign mem.mem_write      = wr_q;
  assign mem.mem_chipselect = wr_q;
  assign mem.mem_address    = addr_q;
  assign mem.mem_writedata  = data_q;
  assign mem.mem_byteenable = 4'hF;

  assign state     = state_q;
  assign done      = (state_q == ST_DONE);
  assign wrapped   = wrap_q;
  assign trig_addr = trig_q;
  assign wr_ptr    = ptr_q;

endmodule

// File: tb/tb_trace_capture_writer.sv
// Directed bench for trace_capture_writer with a negedge memory-write monitor.
module tb_trace_capture_writer;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          arm, abort, trigger;
  logic [AW-1:0] post_count;
  logic [1:0]    state;
  logic          done, wrapped;
  logic [AW-1:0] trig_addr, wr_ptr;

  trace_stream_if #(.DATA_W(DW))            st_if ();
  trace_mem_if    #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  trace_capture_writer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(16384)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .st         (st_if),
    .mem        (mem_if),
    .arm        (arm),
    .abort      (abort),
    .trigger    (trigger),
    .post_count (post_count),
    .state      (state),
    .done       (done),
    .wrapped    (wrapped),
    .trig_addr  (trig_addr),
    .wr_ptr     (wr_ptr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cs_bad   = 0;
  int timing_bad = 0;
  logic prev_xfer = 1'b0;
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Capture every memory write and check it trails its transfer by one cycle.
  always @(negedge clk) begin
    if (mem_if.mem_write === 1'b1) begin
      wr_addr_q.push_back(mem_if.mem_address);
      wr_data_q.push_back(mem_if.mem_writedata);
    end
    if (mem_if.mem_chipselect !== mem_if.mem_write) cs_bad++;
    if (!reset_n) begin
      prev_xfer = 1'b0;
    end else begin
      if (mem_if.mem_write !== prev_xfer) timing_bad++;
      prev_xfer = st_if.st_valid && st_if.st_ready;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int bad;
    reset_n = 1'b0;
    arm = 1'b0; abort = 1'b0; trigger = 1'b0; post_count = '0;
    st_if.st_data = '0; st_if.st_valid = 1'b0;
    repeat (3) step();
    chk("rst_state", state, 0);
    chk("rst_ready", st_if.st_ready, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_mem_write", mem_if.mem_write, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    repeat (3) step();
    chk("byteenable", mem_if.mem_byteenable, 4'hF);

    // Trigger on word 4 with three post words.
    pulse_arm();
    chk("t1_state_pre", state, 1);
    chk("t1_ready", st_if.st_ready, 1);
    clear_log();
    acc = 0;
    post_count = 14'd3;
    for (int i = 0; i < 10; i++) begin
      st_if.st_data = 32'hA0 + i;
      st_if.st_valid = 1'b1;
      trigger = (i == 4);
      if (st_if.st_ready) acc++;
      step();
    end
    st_if.st_valid = 1'b0; trigger = 1'b0;
    repeat (2) step();
    chk("t1_accepted", acc, 8);
    chk("t1_state_done", state, 3);
    chk("t1_done", done, 1);
    chk("t1_trig_addr", trig_addr, 4);
    chk("t1_wr_ptr", wr_ptr, 8);
    chk("t1_writes", wr_addr_q.size(), 8);
    bad = 0;
    foreach (wr_addr_q[k])
      if (wr_addr_q[k] !== AW'(k) || wr_data_q[k] !== 32'hA0 + k) bad++;
    chk("t1_mem_seq", bad, 0);

    // Long run wrapping the whole memory.
    pulse_arm();
    chk("t2_wrapped_cleared", wrapped, 0);
    clear_log();
    acc = 0;
    post_count = 14'd1;
    for (int i = 0; i < 16390; i++) begin
      st_if.st_data = DW'(i);
      st_if.st_valid = 1'b1;
      trigger = (i == 16388);
      if (st_if.st_ready) acc++;
      step();
      if (i == 16382) chk("t2_not_yet_wrapped", wrapped, 0);
      if (i == 16383) chk("t2_wrap_edge", wrapped, 1);
    end
    st_if.st_valid = 1'b0; trigger = 1'b0;
    repeat (2) step();
    chk("t2_accepted", acc, 16390);
    chk("t2_wrapped", wrapped, 1);
    chk("t2_trig_addr", trig_addr, 4);
    chk("t2_wr_ptr", wr_ptr, 6);
    chk("t2_state", state, 3);
    chk("t2_writes", wr_addr_q.size(), 16390);
    bad = 0;
    foreach (wr_addr_q[k])
      if (wr_addr_q[k] !== AW'(k) || wr_data_q[k] !== DW'(k)) bad++;
    chk("t2_mem_seq", bad, 0);

    // Trigger with no data and zero post count.
    pulse_arm();
    clear_log();
    trigger = 1'b1; post_count = '0;
    step();
    trigger = 1'b0;
    chk("t3_state", state, 3);
    chk("t3_done", done, 1);
    chk("t3_trig_addr", trig_addr, 0);
    repeat (2) step();
    chk("t3_writes", wr_addr_q.size(), 0);

    // Abort beats a simultaneous trigger.
    pulse_arm();
    for (int i = 0; i < 3; i++) begin
      st_if.st_data = 32'hB0 + i;
      st_if.st_valid = 1'b1;
      step();
    end
    st_if.st_valid = 1'b0;
    trigger = 1'b1; abort = 1'b1; post_count = 14'd5;
    step();
    trigger = 1'b0; abort = 1'b0;
    chk("t4_state", state, 0);
    chk("t4_ready", st_if.st_ready, 0);
    chk("t4_trig_addr", trig_addr, 0);
    chk("t4_wr_ptr", wr_ptr, 3);
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    chk("t4_abort_over_arm", state, 0);

    // Reset asserted in the middle of a capture.
    pulse_arm();
    post_count = 14'd10;
    for (int i = 0; i < 5; i++) begin
      st_if.st_data = 32'h50 + i;
      st_if.st_valid = 1'b1;
      trigger = (i == 2);
      step();
    end
    trigger = 1'b0;
    chk("t5_pre_state", state, 2);
    chk("t5_pre_trig", trig_addr, 2);
    chk("t5_write_pending", mem_if.mem_write, 1);
    clear_log();
    reset_n = 1'b0;
    #1;
    chk("t5_state", state, 0);
    chk("t5_ready", st_if.st_ready, 0);
    chk("t5_mem_write", mem_if.mem_write, 0);
    chk("t5_mem_cs", mem_if.mem_chipselect, 0);
    chk("t5_mem_addr", mem_if.mem_address, 0);
    chk("t5_mem_data", mem_if.mem_writedata, 0);
    chk("t5_wr_ptr", wr_ptr, 0);
    chk("t5_trig_addr", trig_addr, 0);
    chk("t5_wrapped", wrapped, 0);
    chk("t5_done", done, 0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (4) step();
    st_if.st_valid = 1'b0;
    chk("t5_no_writes", wr_addr_q.size(), 0);

    // Throttled stream, one valid in three cycles.
    pulse_arm();
    clear_log();
    post_count = 14'd2;
    for (int c = 0; c < 15; c++) begin
      st_if.st_data = 32'hC0 + c;
      st_if.st_valid = (c % 3 == 0);
      trigger = (c == 3);
      step();
    end
    st_if.st_valid = 1'b0; trigger = 1'b0;
    repeat (2) step();
    chk("t6_state", state, 3);
    chk("t6_trig_addr", trig_addr, 1);
    chk("t6_writes", wr_addr_q.size(), 4);
    bad = 0;
    foreach (wr_addr_q[k])
      if (wr_addr_q[k] !== AW'(k) || wr_data_q[k] !== 32'hC0 + 3 * k) bad++;
    chk("t6_mem_seq", bad, 0);
    chk("write_timing", timing_bad, 0);
    chk("cs_equals_write", cs_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
